// File: rtl/lives_hud_pkg.sv
// Shared definitions for the lives HUD: FSM states, tile colours, banner geometry
// and a span hit-test helper. Optional feature macro: LIVES_HUD_BANNER_EN.
package lives_hud_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_OVER  = 2'd2
  } hud_state_e;

  localparam logic [11:0] HEART_RGB  = 12'hF00;
  localparam logic [11:0] LOST_RGB   = 12'hFFF;
  localparam logic [11:0] BANNER_RGB = 12'hFF0;

  // Game-over banner rectangle, inclusive bounds
  localparam int unsigned BANNER_X0 = 224;
  localparam int unsigned BANNER_X1 = 415;
  localparam int unsigned BANNER_Y0 = 224;
  localparam int unsigned BANNER_Y1 = 255;

  // True when v lies in [lo, lo+len); 11-bit math so HUD coordinates never wrap
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/lives_hud_blinker.sv
// Frame timing for the lives HUD: frame-tick edge detector on (x,y)==(0,0),
// frame counter and blink phase with clear/enable controls.
module lives_hud_blinker
  import lives_hud_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 8,
  parameter int unsigned CNT_W        = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             blink_ph_o
);

  logic             origin_q, origin_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  // Tick on the first clk at the origin; counter advances/toggles when enabled
  always_comb begin
    origin_d    = (x == '0) && (y == '0);
    tick_o      = origin_d && !origin_q;
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (clr_i) begin
      frame_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (en_i) begin
      // Counter wraps naturally; with power-of-two blink periods the phase stays aligned
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if ((32'(frame_cnt_q) % BLINK_FRAMES) == (BLINK_FRAMES - 1))
        blink_ph_d = !blink_ph_q;
    end
  end

  // Timing state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      origin_q    <= 1'b0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      origin_q    <= origin_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign blink_ph_o  = blink_ph_q;

endmodule

// File: rtl/lives_hud.sv
// Lives HUD layer: one heart tile per remaining life, blinking tile for the most
// recently lost life, registered pixel output (1-clk latency).
// Optional feature macro: LIVES_HUD_BANNER_EN (blinking game-over banner in OVER).
module lives_hud
  import lives_hud_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = 5,
  parameter int unsigned HUD_X0       = 8,
  parameter int unsigned HUD_Y0       = 8,
  parameter int unsigned TILE_W       = 16,
  parameter int unsigned TILE_GAP     = 4,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [2:0]  lives,
  input  logic        gameover,
  output logic        hud_on,
  output logic [11:0] hud_rgb
);

  localparam int unsigned CNT_W = $clog2(FLASH_FRAMES);

  hud_state_e       state_q, state_d;
  logic [2:0]       flash_idx_q, flash_idx_d;
  logic [2:0]       lives_prev_q, lives_prev_d;
  logic             hud_on_q, hud_on_d;
  logic [11:0]      hud_rgb_q, hud_rgb_d;

  logic             tick;
  logic             blk_clr, blk_en;
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_ph;
  logic             loss, gain;
  logic [2:0]       lives_c;
  logic [10:0]      x11, y11;
  logic             row_hit;

  lives_hud_blinker #(
    .BLINK_FRAMES(BLINK_FRAMES),
    .CNT_W       (CNT_W)
  ) u_blinker (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .clr_i      (blk_clr),
    .en_i       (blk_en),
    .tick_o     (tick),
    .frame_cnt_o(frame_cnt),
    .blink_ph_o (blink_ph)
  );

  assign loss    = lives < lives_prev_q;
  assign gain    = lives > lives_prev_q;
  assign lives_c = (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;
  assign x11     = {1'b0, x};
  assign y11     = {1'b0, y};
  assign row_hit = in_span(y11, 11'(HUD_Y0), 11'(TILE_W));

  // Next state: gameover first, then gain, then loss, then flash timeout / OVER exit
  always_comb begin
    state_d      = state_q;
    flash_idx_d  = flash_idx_q;
    lives_prev_d = lives;
    blk_clr      = 1'b0;
    blk_en       = 1'b0;
    if (gameover) begin
      state_d = ST_OVER;
      if (state_q != ST_OVER) blk_clr = 1'b1;
`ifdef LIVES_HUD_BANNER_EN
      else blk_en = tick;
`endif
    end else if (gain) begin
      state_d = ST_IDLE;
      blk_clr = 1'b1;
    end else if (loss) begin
      state_d     = ST_FLASH;
      flash_idx_d = lives;
      blk_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_FLASH: begin
          if (tick) begin
            if (frame_cnt == CNT_W'(FLASH_FRAMES - 1)) state_d = ST_IDLE;
            else blk_en = 1'b1;
          end
        end
        ST_OVER: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Pixel hit-test for heart tiles (and banner when enabled)
  always_comb begin
    hud_on_d  = 1'b0;
    hud_rgb_d = '0;
    if (state_q != ST_OVER && row_hit) begin
      for (int unsigned i = 0; i < MAX_LIVES; i++) begin
        if (in_span(x11, 11'(HUD_X0 + i * (TILE_W + TILE_GAP)), 11'(TILE_W))) begin
          if (3'(i) < lives_c) begin
            hud_on_d  = 1'b1;
            hud_rgb_d = HEART_RGB;
          end else if (state_q == ST_FLASH && flash_idx_q == 3'(i) && blink_ph) begin
            hud_on_d  = 1'b1;
            hud_rgb_d = LOST_RGB;
          end
        end
      end
    end
`ifdef LIVES_HUD_BANNER_EN
    if (state_q == ST_OVER && blink_ph &&
        x11 >= 11'(BANNER_X0) && x11 <= 11'(BANNER_X1) &&
        y11 >= 11'(BANNER_Y0) && y11 <= 11'(BANNER_Y1)) begin
      hud_on_d  = 1'b1;
      hud_rgb_d = BANNER_RGB;
    end
`endif
  end

  // FSM, history and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      flash_idx_q  <= '0;
      lives_prev_q <= 3'(MAX_LIVES);
      hud_on_q     <= 1'b0;
      hud_rgb_q    <= '0;
    end else begin
      state_q      <= state_d;
      flash_idx_q  <= flash_idx_d;
      lives_prev_q <= lives_prev_d;
      hud_on_q     <= hud_on_d;
      hud_rgb_q    <= hud_rgb_d;
    end
  end

  assign hud_on  = hud_on_q;
  assign hud_rgb = hud_rgb_q;

endmodule

// File: tb/tb_lives_hud.sv
// Scoreboard bench for lives_hud: stimulus pushes the expected registered pixel
// for each clk, a monitor pops and compares one clk later.
module tb_lives_hud;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic [2:0]  lives;
  logic        gameover;
  logic        hud_on;
  logic [11:0] hud_rgb;

  always #5 clk = ~clk;

  lives_hud #(
    .MAX_LIVES(5), .HUD_X0(8), .HUD_Y0(8), .TILE_W(16), .TILE_GAP(4),
    .FLASH_FRAMES(60), .BLINK_FRAMES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .lives(lives),
    .gameover(gameover), .hud_on(hud_on), .hud_rgb(hud_rgb)
  );

  typedef struct {
    int         px;
    int         py;
    logic       on;
    logic [11:0] rgb;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // Requested inputs for the next clk
  int t_lives = 5;
  bit t_go    = 1'b0;
  bit t_rstn  = 1'b0;

  // Reference model: mode, last lives seen, lost tile, ticks since mode entry
  localparam int M_IDLE = 0, M_FLASH = 1, M_OVER = 2;
  int m_mode = M_IDLE;
  int m_prev = 5;
  int m_idx  = 0;
  int m_f    = 0;
  bit m_orig = 1'b0;

  task automatic model_update(input int px, input int py);
    bit tick;
    if (!t_rstn) begin
      m_mode = M_IDLE; m_f = 0; m_prev = 5; m_orig = 1'b0;
      return;
    end
    tick   = (px == 0 && py == 0) && !m_orig;
    m_orig = (px == 0 && py == 0);
    if (t_go) begin
      if (m_mode != M_OVER) begin m_mode = M_OVER; m_f = 0; end
      else if (tick) m_f++;
    end else if (t_lives > m_prev) begin
      m_mode = M_IDLE; m_f = 0;
    end else if (t_lives < m_prev) begin
      m_mode = M_FLASH; m_idx = t_lives; m_f = 0;
    end else if (m_mode == M_FLASH && tick) begin
      if (m_f == 59) m_mode = M_IDLE;
      else m_f++;
    end else if (m_mode == M_OVER) begin
      m_mode = M_IDLE;
    end
    m_prev = t_lives;
  endtask

  task automatic cyc(input int px, input int py);
    exp_t e;
    int   lc, dx, tile;
    bit   vis;
    @(negedge clk);
    reset_n  = t_rstn;
    x        = 10'(px);
    y        = 10'(py);
    lives    = 3'(t_lives);
    gameover = t_go;
    e.px = px; e.py = py; e.on = 1'b0; e.rgb = 12'h000;
    if (t_rstn) begin
      lc   = (t_lives > 5) ? 5 : t_lives;
      vis  = ((m_f / 8) % 2) == 0;
      tile = -1;
      dx   = px - 8;
      if (dx >= 0 && (dx % 20) < 16 && (dx / 20) < 5 && py >= 8 && py < 24) tile = dx / 20;
      if (m_mode != M_OVER && tile >= 0) begin
        if (tile < lc) begin
          e.on = 1'b1; e.rgb = 12'hF00;
        end else if (m_mode == M_FLASH && tile == m_idx && vis) begin
          e.on = 1'b1; e.rgb = 12'hFFF;
        end
      end
`ifdef LIVES_HUD_BANNER_EN
      if (m_mode == M_OVER && vis && px >= 224 && px <= 415 && py >= 224 && py <= 255) begin
        e.on = 1'b1; e.rgb = 12'hFF0;
      end
`endif
    end
    sbq.push_back(e);
    mon_en = 1'b1;
    model_update(px, py);
  endtask

  task automatic rand_pix();
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0, 1:    cyc($urandom_range(1, 110), $urandom_range(0, 30));
      2:       cyc($urandom_range(215, 425), $urandom_range(215, 265));
      default: cyc($urandom_range(1, 1023), $urandom_range(0, 1023));
    endcase
  endtask

  task automatic frame(input int n);
    cyc(0, 0);
    repeat (n) rand_pix();
  endtask

  task automatic frame_rand();
    int chg;
    chg = $urandom_range(0, 7) == 0 ? $urandom_range(0, 29) : -1;
    cyc(0, 0);
    for (int k = 0; k < 30; k++) begin
      if (k == chg) begin
        t_lives = $urandom_range(0, 7);
        t_go    = (t_lives == 0);
      end
      rand_pix();
    end
  endtask

  // Monitor: one registered pixel per clk, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: got on=%b rgb=%h, required an expected entry", hud_on, hud_rgb);
        end else begin
          e = sbq.pop_front();
          if (hud_on !== e.on || hud_rgb !== e.rgb)begin
            bad++;
            $display("FAIL pixel(%0d,%0d): got on=%b rgb=%h, required on=%b rgb=%h",
                     e.px, e.py, hud_on, hud_rgb, e.on, e.rgb);
          end
        end
      end
    end
  end

  initial begin
    // Reset with lives=5
    t_rstn = 1'b0; t_lives = 5; t_go = 1'b0;
    cyc(5, 5); cyc(8, 8);
    t_rstn = 1'b1;

    // Full scan of the HUD region: five hearts at x=8,28,48,68,88
    cyc(0, 0);
    for (int yy = 6; yy < 26; yy++)
      for (int xx = 0; xx < 110; xx++) cyc(xx, yy);
    repeat (3) frame(30);

    // Loss 5->4 mid-frame, then let the flash run out
    cyc(0, 0);
    repeat (10) rand_pix();
    t_lives = 4;
    repeat (20) rand_pix();
    repeat (70) frame(30);

    // Restart a flash, then lose another life at frame 20
    t_lives = 5; frame(30);
    t_lives = 4; frame(30);
    repeat (19) frame(30);
    t_lives = 3;
    repeat (70) frame(30);

    // Down to one life, then game over mid-flash
    t_lives = 2; repeat (5) frame(30);
    t_lives = 1; repeat (10) frame(30);
    cyc(0, 0);
    repeat (5) rand_pix();
    t_lives = 0; t_go = 1'b1;
    repeat (10) rand_pix();
    repeat (40) frame(30);

    // Game restart: gameover drops and lives refill together
    t_go = 1'b0; t_lives = 5;
    repeat (5) frame(30);

    // Reset pulse mid-flash, then origin held for three clks
    t_lives = 4; repeat (10) frame(30);
    t_rstn = 1'b0; cyc(50, 10);
    t_rstn = 1'b1;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    repeat (30) rand_pix();
    repeat (20) frame(30);

    // Randomised play
    repeat (150) frame_rand();

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
